rns_error_poly_sched: RTL and testbench

Sequences the RNS error-polynomial conversion datapath across all RNS moduli of a ciphertext level. Per modulus: selects q from a small moduli table, sweeps coefficient addresses 0..N-1 into the datapath, drains the read/write pipeline, then advances to the next modulus and write bank. Sits between the encryption top-level FSM (start/done) and the error-poly conversion datapath plus its destination BRAM banks.

---
 rtl/rns_error_poly_sched_pkg.sv | 16 +
 rtl/rns_moduli_table.sv | 32 +++
 rtl/rns_error_poly_sched.sv | 157 +++++++++++++++
 tb/tb_rns_error_poly_sched.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rns_error_poly_sched_pkg.sv
// Shared types and constants for the RNS error-polynomial conversion scheduler.
package rns_error_poly_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SWEEP  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  localparam int unsigned DEF_BRAM_RD_LAT = 2;
  // Idle cycles after the last address so the final datapath write lands on the old bank.
  localparam int unsigned DRAIN_CYCLES    = DEF_BRAM_RD_LAT + 2;

endpackage

// File: rtl/rns_moduli_table.sv
// RNS moduli register file: one write port, one registered read port.
module rns_moduli_table #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDXW  = 3,
  parameter int unsigned DW    = 54
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_wr_en,
  input  logic [IDXW-1:0] i_wr_idx,
  input  logic [DW-1:0]   i_wr_data,
  input  logic            i_rd_en,
  input  logic [IDXW-1:0] i_rd_idx,
  output logic [DW-1:0]   o_rd_data
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_data;

  // Storage has no reset; contents must be rewritten after reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_idx] <= i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_idx];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/rns_error_poly_sched.sv
// Sequences coefficient address sweeps over every configured RNS modulus,
// holding q and the destination bank until the datapath pipeline has drained.
module rns_error_poly_sched
  import rns_error_poly_sched_pkg::*;
#(
  parameter int unsigned N           = 8192,
  parameter int unsigned LOGN        = 13,
  parameter int unsigned LOGQ        = 54,
  parameter int unsigned MAX_MODULI  = 8,
  parameter int unsigned LOGL        = 3,
  parameter int unsigned BRAM_RD_LAT = DEF_BRAM_RD_LAT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [LOGL-1:0] cfg_idx,
  input  logic [LOGQ-1:0] cfg_q,
  input  logic            start,
  input  logic [LOGL-1:0] num_moduli_m1,
  input  logic            abort,
  output logic [LOGQ-1:0] q,
  output logic [LOGN-1:0] read_addr_DP,
  output logic            done_internal,
  output logic [LOGL-1:0] wr_bank,
  output logic            busy,
  output logic            done,
  output logic            aborted
);

  localparam int unsigned DRAIN_LEN = BRAM_RD_LAT + 2;
  localparam int unsigned DCW       = $clog2(DRAIN_LEN + 1);

  state_e          r_state, w_next;
  logic [LOGL-1:0] r_m_idx, w_m_idx_nxt;
  logic [LOGL-1:0] r_num_m1, w_num_m1_nxt;
  logic [LOGN-1:0] r_addr_cnt, w_addr_cnt_nxt;
  logic [DCW-1:0]  r_drain_cnt, w_drain_cnt_nxt;
  logic            r_abort_flag, w_abort_flag_nxt;
  logic [LOGN-1:0] r_read_addr, w_read_addr_nxt;
  logic [LOGL-1:0] r_wr_bank, w_wr_bank_nxt;
  logic            r_done_internal, r_busy, r_done, r_aborted;
  logic            w_tbl_rd_en;
  logic [LOGQ-1:0] w_tbl_q;

  rns_moduli_table #(
    .DEPTH (MAX_MODULI),
    .IDXW  (LOGL),
    .DW    (LOGQ)
  ) u_table (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_wr_en   (cfg_we && (r_state == ST_IDLE)),
    .i_wr_idx  (cfg_idx),
    .i_wr_data (cfg_q),
    .i_rd_en   (w_tbl_rd_en),
    .i_rd_idx  (r_m_idx),
    .o_rd_data (w_tbl_q)
  );

  // Next-state and next-register values.
  always_comb begin
    w_next           = r_state;
    w_m_idx_nxt      = r_m_idx;
    w_num_m1_nxt     = r_num_m1;
    w_addr_cnt_nxt   = r_addr_cnt;
    w_drain_cnt_nxt  = r_drain_cnt;
    w_abort_flag_nxt = r_abort_flag;
    w_read_addr_nxt  = r_read_addr;
    w_wr_bank_nxt    = r_wr_bank;
    w_tbl_rd_en      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next           = ST_LOAD;
          w_num_m1_nxt     = num_moduli_m1;
          w_m_idx_nxt      = '0;
          w_abort_flag_nxt = 1'b0;
        end
      end
      ST_LOAD: begin
        w_tbl_rd_en    = 1'b1;
        w_wr_bank_nxt  = r_m_idx;
        w_addr_cnt_nxt = '0;
        if (abort) begin
          w_abort_flag_nxt = 1'b1;
          w_drain_cnt_nxt  = '0;
          w_next           = ST_DRAIN;
        end else begin
          w_next = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        w_read_addr_nxt = r_addr_cnt;
        w_addr_cnt_nxt  = r_addr_cnt + 1'b1;
        if (abort) w_abort_flag_nxt = 1'b1;
        if (abort || (r_addr_cnt == LOGN'(N - 1))) begin
          w_drain_cnt_nxt = '0;
          w_next          = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort) w_abort_flag_nxt = 1'b1;
        if (r_drain_cnt == DCW'(DRAIN_LEN - 1)) begin
          if (r_abort_flag || abort || (r_m_idx == r_num_m1)) begin
            w_next = ST_FINISH;
          end else begin
            w_m_idx_nxt = r_m_idx + 1'b1;
            w_next      = ST_LOAD;
          end
        end else begin
          w_drain_cnt_nxt = r_drain_cnt + 1'b1;
        end
      end
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= ST_IDLE;
      r_m_idx         <= '0;
      r_num_m1        <= '0;
      r_addr_cnt      <= '0;
      r_drain_cnt     <= '0;
      r_abort_flag    <= 1'b0;
      r_read_addr     <= '0;
      r_wr_bank       <= '0;
      r_done_internal <= 1'b1;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_aborted       <= 1'b0;
    end else begin
      r_state         <= w_next;
      r_m_idx         <= w_m_idx_nxt;
      r_num_m1        <= w_num_m1_nxt;
      r_addr_cnt      <= w_addr_cnt_nxt;
      r_drain_cnt     <= w_drain_cnt_nxt;
      r_abort_flag    <= w_abort_flag_nxt;
      r_read_addr     <= w_read_addr_nxt;
      r_wr_bank       <= w_wr_bank_nxt;
      r_done_internal <= (w_next != ST_SWEEP);
      r_busy          <= (w_next != ST_IDLE);
      r_done          <= (w_next == ST_FINISH) && !w_abort_flag_nxt;
      r_aborted       <= (w_next == ST_FINISH) && w_abort_flag_nxt;
    end
  end

  assign q             = w_tbl_q;
  assign read_addr_DP  = r_read_addr;
  assign done_internal = r_done_internal;
  assign wr_bank       = r_wr_bank;
  assign busy          = r_busy;
  assign done          = r_done;
  assign aborted       = r_aborted;

endmodule

// File: tb/tb_rns_error_poly_sched.sv
// Self-checking bench: a datapath model records writes, compared against the
// write list implied by the moduli table and the run parameters.
module tb_rns_error_poly_sched;

  localparam int unsigned N       = 16;
  localparam int unsigned LOGN    = 4;
  localparam int unsigned LOGQ    = 54;
  localparam int unsigned MAXM    = 8;
  localparam int unsigned LOGL    = 3;
  localparam int unsigned LAT     = 2;
  localparam int          PER_MOD = 1 + N + LAT + 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cfg_we = 1'b0;
  logic [LOGL-1:0] cfg_idx = '0;
  logic [LOGQ-1:0] cfg_q = '0;
  logic            start = 1'b0;
  logic [LOGL-1:0] num_moduli_m1 = '0;
  logic            abort = 1'b0;
  logic [LOGQ-1:0] q;
  logic [LOGN-1:0] read_addr_DP;
  logic            done_internal;
  logic [LOGL-1:0] wr_bank;
  logic            busy, done, aborted;

  always #5 clk = ~clk;

  rns_error_poly_sched #(
    .N(N), .LOGN(LOGN), .LOGQ(LOGQ), .MAX_MODULI(MAXM), .LOGL(LOGL), .BRAM_RD_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_q(cfg_q),
    .start(start), .num_moduli_m1(num_moduli_m1), .abort(abort), .q(q),
    .read_addr_DP(read_addr_DP), .done_internal(done_internal), .wr_bank(wr_bank),
    .busy(busy), .done(done), .aborted(aborted)
  );

  typedef struct packed {
    logic [LOGQ-1:0] q;
    logic [LOGL-1:0] bank;
    logic [LOGN-1:0] addr;
  } wr_t;

  wr_t             got[$];
  wr_t             exp_w[$];
  logic [LOGQ-1:0] tbl [MAXM];
  int              n_tests = 0;
  int              n_fail  = 0;

  int              cyc, low_cnt;
  logic            di_d1, di_d2, di_d3;
  logic [LOGN-1:0] ra_d1, ra_d2;

  int              done_t, abort_t, n_done, n_abort, abort_set_t;
  logic            di_after_abort, q_unstable;

  // Datapath model: wea is done_internal inverted and delayed 3, wr_addr is read_addr_DP delayed 2.
  task automatic model_clear();
    di_d1 = 1'b1; di_d2 = 1'b1; di_d3 = 1'b1;
    ra_d1 = '0;   ra_d2 = '0;
    got.delete();
  endtask

  task automatic tick();
    wr_t w;
    @(posedge clk);
    #1;
    cyc++;
    if (di_d3 == 1'b0) begin
      w.q = q; w.bank = wr_bank; w.addr = ra_d2;
      got.push_back(w);
    end
    di_d3 = di_d2; di_d2 = di_d1; di_d1 = done_internal;
    ra_d2 = ra_d1; ra_d1 = read_addr_DP;
    if (!done_internal) low_cnt++;
  endtask

  function automatic logic [LOGQ-1:0] rand_q();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return LOGQ'(v) | {{(LOGQ-1){1'b0}}, 1'b1};
  endfunction

  task automatic write_table(input int idx, input logic [LOGQ-1:0] val);
    cfg_we = 1'b1; cfg_idx = LOGL'(idx); cfg_q = val;
    tick();
    cfg_we = 1'b0;
    tbl[idx] = val;
  endtask

  // Reference write list: every modulus m, addresses 0..N-1 (or 0..last_addr on abort).
  function automatic void build_expected(input int num_m1, input int last_addr);
    wr_t w;
    exp_w.delete();
    for (int m = 0; m <= num_m1; m++)
      for (int a = 0; a < N; a++)
        if (last_addr < 0 || a <= last_addr) begin
          w.q = tbl[m]; w.bank = LOGL'(m); w.addr = LOGN'(a);
          exp_w.push_back(w);
        end
  endfunction

  function automatic int first_diff();
    if (got.size() != exp_w.size()) return -2;
    foreach (got[i]) if (got[i] !== exp_w[i]) return i;
    return -1;
  endfunction

  // Start one run; optional abort at a given address and optional busy-time pokes.
  task automatic run_seq(input int num_m1, input int abort_addr, input bit poke_busy);
    model_clear();
    cyc = 0; low_cnt = 0; done_t = -1; abort_t = -1; n_done = 0; n_abort = 0;
    abort_set_t = -1; di_after_abort = 1'bx; q_unstable = 1'b0;
    num_moduli_m1 = LOGL'(num_m1); start = 1'b1;
    tick();
    start = 1'b0; num_moduli_m1 = LOGL'($urandom);
    for (int k = 0; k < 400; k++) begin
      if (done)    begin n_done++;  done_t  = cyc; end
      if (aborted) begin n_abort++; abort_t = cyc; end
      if (abort_set_t >= 0 && cyc == abort_set_t + 1) di_after_abort = done_internal;
      if (abort_set_t >= 0 && cyc > abort_set_t && abort_t < 0 && q !== tbl[0]) q_unstable = 1'b1;
      abort = 1'b0; start = 1'b0; cfg_we = 1'b0;
      if (!done_internal && low_cnt == abort_addr + 1) begin abort = 1'b1; abort_set_t = cyc; end
      if (poke_busy && !done_internal && low_cnt == 8) begin
        start = 1'b1; cfg_we = 1'b1; cfg_idx = '0; cfg_q = rand_q();
      end
      if ((done_t >= 0 && cyc >= done_t + 6) || (abort_t >= 0 && cyc >= abort_t + 6)) break;
      tick();
    end
    abort = 1'b0; start = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({q, read_addr_DP, done_internal, wr_bank, busy, done, aborted} !==
        {{LOGQ{1'b0}}, {LOGN{1'b0}}, 1'b1, {LOGL{1'b0}}, 3'b000}) begin
      $display("FAIL reset_outputs q=%0d ra=%0d di=%b bank=%0d busy=%b done=%b ab=%b expected 0/0/1/0/0/0/0",
               q, read_addr_DP, done_internal, wr_bank, busy, done, aborted);
      n_fail++;
    end
    rst = 1'b1;
    cyc = 0; low_cnt = 0;
    model_clear();
    tick();
  endtask

  task automatic test_two_moduli();
    int d;
    write_table(0, 54'd97);
    write_table(1, 54'd193);
    run_seq(1, -1, 1'b0);
    build_expected(1, -1);
    n_tests++;
    if (done_t != 2 * PER_MOD + 1) begin
      $display("FAIL two_mod_done_time got=%0d expected=%0d", done_t, 2 * PER_MOD + 1); n_fail++;
    end
    n_tests++;
    if (n_done != 1 || n_abort != 0) begin
      $display("FAIL two_mod_pulses done=%0d aborted=%0d expected 1/0", n_done, n_abort); n_fail++;
    end
    d = first_diff();
    n_tests++;
    if (d != -1) begin
      $display("FAIL two_mod_writes diff_at=%0d got_n=%0d expected_n=%0d", d, got.size(), exp_w.size()); n_fail++;
    end
    n_tests++;
    if (busy !== 1'b0 || wr_bank !== 3'd1 || q !== 54'd193) begin
      $display("FAIL two_mod_end busy=%b bank=%0d q=%0d expected 0/1/193", busy, wr_bank, q); n_fail++;
    end
  endtask

  task automatic test_single_modulus();
    int d;
    run_seq(0, -1, 1'b0);
    build_expected(0, -1);
    n_tests++;
    if (done_t != PER_MOD + 1) begin
      $display("FAIL one_mod_done_time got=%0d expected=%0d", done_t, PER_MOD + 1); n_fail++;
    end
    d = first_diff();
    n_tests++;
    if (d != -1) begin
      $display("FAIL one_mod_writes diff_at=%0d got_n=%0d expected_n=%0d", d, got.size(), exp_w.size()); n_fail++;
    end
    n_tests++;
    if (wr_bank !== 3'd0 || q !== 54'd97) begin
      $display("FAIL one_mod_end bank=%0d q=%0d expected 0/97", wr_bank, q); n_fail++;
    end
  endtask

  task automatic test_abort();
    int d;
    run_seq(1, 5, 1'b0);
    build_expected(0, 5);
    n_tests++;
    if (n_abort != 1 || n_done != 0) begin
      $display("FAIL abort_pulses aborted=%0d done=%0d expected 1/0", n_abort, n_done); n_fail++;
    end
    n_tests++;
    if (abort_set_t < 0 || abort_t != abort_set_t + LAT + 3) begin
      $display("FAIL abort_time got=%0d expected=%0d", abort_t, abort_set_t + LAT + 3); n_fail++;
    end
    n_tests++;
    if (di_after_abort !== 1'b1 || q_unstable !== 1'b0) begin
      $display("FAIL abort_stop di_next=%b q_unstable=%b expected 1/0", di_after_abort, q_unstable); n_fail++;
    end
    d = first_diff();
    n_tests++;
    if (d != -1) begin
      $display("FAIL abort_writes diff_at=%0d got_n=%0d expected_n=%0d", d, got.size(), exp_w.size()); n_fail++;
    end
    n_tests++;
    if (busy !== 1'b0) begin
      $display("FAIL abort_idle busy=%b expected 0", busy); n_fail++;
    end
  endtask

  task automatic test_busy_ignored();
    int d;
    run_seq(1, -1, 1'b1);
    build_expected(1, -1);
    n_tests++;
    if (done_t != 2 * PER_MOD + 1 || n_done != 1) begin
      $display("FAIL busy_poke_done got_t=%0d n=%0d expected_t=%0d n=1", done_t, n_done, 2 * PER_MOD + 1); n_fail++;
    end
    d = first_diff();
    n_tests++;
    if (d != -1) begin
      $display("FAIL busy_poke_writes diff_at=%0d got_n=%0d expected_n=%0d", d, got.size(), exp_w.size()); n_fail++;
    end
    run_seq(0, -1, 1'b0);
    n_tests++;
    if (got.size() == 0 || got[0].q !== 54'd97) begin
      $display("FAIL busy_poke_table got_n=%0d q0=%0d expected q0=97", got.size(),
               (got.size() != 0) ? got[0].q : 54'd0);
      n_fail++;
    end
  endtask

  task automatic test_async_reset();
    int d;
    model_clear();
    cyc = 0; low_cnt = 0;
    num_moduli_m1 = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (!done_internal && low_cnt == 10) break;
      tick();
    end
    n_tests++;
    if (read_addr_DP !== 4'd8 || done_internal !== 1'b0) begin
      $display("FAIL areset_reach ra=%0d di=%b expected 8/0", read_addr_DP, done_internal); n_fail++;
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({q, read_addr_DP, done_internal, wr_bank, busy, done, aborted} !==
        {{LOGQ{1'b0}}, {LOGN{1'b0}}, 1'b1, {LOGL{1'b0}}, 3'b000}) begin
      $display("FAIL areset_outputs q=%0d ra=%0d di=%b bank=%0d busy=%b done=%b ab=%b expected 0/0/1/0/0/0/0",
               q, read_addr_DP, done_internal, wr_bank, busy, done, aborted);
      n_fail++;
    end
    #2 rst = 1'b1;
    tick();
    write_table(0, rand_q());
    write_table(1, rand_q());
    run_seq(1, -1, 1'b0);
    build_expected(1, -1);
    d = first_diff();
    n_tests++;
    if (d != -1 || done_t != 2 * PER_MOD + 1) begin
      $display("FAIL areset_rerun diff_at=%0d done_t=%0d expected -1/%0d", d, done_t, 2 * PER_MOD + 1); n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int d, m;
    for (int i = 0; i < MAXM; i++) write_table(i, rand_q());
    for (int it = 0; it < 4; it++) begin
      m = int'($urandom_range(MAXM - 1, 0));
      if ($urandom_range(1, 0) == 1) write_table(int'($urandom_range(MAXM - 1, 0)), rand_q());
      run_seq(m, -1, 1'b0);
      build_expected(m, -1);
      d = first_diff();
      n_tests++;
      if (d != -1 || done_t != (m + 1) * PER_MOD + 1 || n_done != 1) begin
        $display("FAIL b2b_run%0d m1=%0d diff_at=%0d done_t=%0d n_done=%0d expected -1/%0d/1",
                 it, m, d, done_t, n_done, (m + 1) * PER_MOD + 1);
        n_fail++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_moduli();
    test_single_modulus();
    test_abort();
    test_busy_ignored();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
